// File: rtl/scanner_pkg.sv
// Shared definitions for the scanner pair and its transfer receiver:
// comm codes, scanner and receiver state encodings, default word width.
package scanner_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        INACTIVE      = 2'b00,
        GO_TO_STANDBY = 2'b01,
        START_SCAN    = 2'b10,
        START_FLUSH   = 2'b11
    } comm_t;

    // READY_TO_TRANSFER is signalled on the GO_TO_STANDBY code
    localparam comm_t READY_TO_TRANSFER = GO_TO_STANDBY;

    typedef enum logic [2:0] {
        SCAN_IDLE     = 3'b000,
        SCAN_STANDBY  = 3'b001,
        SCAN_SCANNING = 3'b010,
        SCAN_FLUSHING = 3'b011,
        SCAN_READY    = 3'b100
    } scan_state_t;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'b000,
        RX_GRANT   = 3'b001,
        RX_RECEIVE = 3'b010,
        RX_DONE    = 3'b011,
        RX_ERROR   = 3'b100
    } rx_state_t;

endpackage

// File: rtl/rx_commit_fifo.sv
// FIFO with a speculative (working) write pointer that is either committed
// to the reader or rolled back; show-ahead read of committed data only.
module rx_commit_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         commit,
    input  logic                         rollback,
    input  logic                         rd_en,
    output logic                         wr_full,
    output logic                         rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       commit_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       used;
    logic [AW:0]       working_used;
    logic              pop;

    assign used         = commit_ptr - rd_ptr;
    assign working_used = wr_ptr - rd_ptr;
    assign count        = CW'(used);
    assign wr_full      = (working_used == FULL_LEVEL);
    assign rd_valid     = (used != '0);
    assign rd_data      = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign pop          = rd_en && rd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            if (rollback)
                wr_ptr <= commit_ptr;
            else if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (commit)
                commit_ptr <= wr_ptr;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rollback)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/scan_transfer_receiver.sv
// Receiving end of the scanner transfer protocol: grant, stream in, commit or
// roll back. Optional macro RX_CHECKSUM_EN adds a running-XOR check on tx_last.
module scan_transfer_receiver
    import scanner_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  scan_comm,
    input  logic [3:0]                  scan_count,
    output logic                        start_transfer,
    input  logic                        tx_valid,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_last,
    input  logic [DATA_W-1:0]           tx_chk,
    output logic                        tx_ready,
    input  logic                        rd_en,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0]  fill_count,
    output logic [2:0]                  state_code,
    output logic                        xfer_error
);

    localparam int unsigned TW = $clog2(TIMEOUT+1);

    rx_state_t   state, state_next;
    logic [3:0]  expected, expected_next;
    logic [TW-1:0] timer, timer_next;
    logic        wr_en, commit, rollback, wr_full, chk_ok, space_ok;
    logic [31:0] space;

    assign space      = DEPTH - 32'(fill_count);
    assign space_ok   = (space >= 32'(scan_count));
    assign state_code = state;

`ifdef RX_CHECKSUM_EN
    logic [DATA_W-1:0] chk_acc;

    always_ff @(posedge clk) begin
        if (reset || state == RX_GRANT)
            chk_acc <= '0;
        else if (wr_en)
            chk_acc <= chk_acc ^ tx_data;
    end

    assign chk_ok = ((chk_acc ^ tx_data) == tx_chk);
`else
    logic unused_chk;
    assign unused_chk = ^tx_chk;
    assign chk_ok     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RX_IDLE;
            expected   <= '0;
            timer      <= '0;
            xfer_error <= 1'b0;
        end else begin
            state    <= state_next;
            expected <= expected_next;
            timer    <= timer_next;
            if (state == RX_ERROR)
                xfer_error <= 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        expected_next  = expected;
        timer_next     = timer;
        start_transfer = 1'b0;
        tx_ready       = 1'b0;
        wr_en          = 1'b0;
        commit         = 1'b0;
        rollback       = 1'b0;
        case (state)
            RX_IDLE: begin
                if (scan_comm == READY_TO_TRANSFER && scan_count != '0 && space_ok)
                    state_next = RX_GRANT;
            end
            RX_GRANT: begin
                start_transfer = 1'b1;
                expected_next  = scan_count;
                timer_next     = '0;
                state_next     = RX_RECEIVE;
            end
            RX_RECEIVE: begin
                tx_ready = !wr_full;
                // flush wins over a word offered in the same cycle
                if (scan_comm == START_FLUSH) begin
                    rollback   = 1'b1;
                    state_next = RX_IDLE;
                end else if (tx_valid && !wr_full) begin
                    wr_en         = 1'b1;
                    expected_next = expected - 1'b1;
                    timer_next    = '0;
                    if (tx_last)
                        state_next = (expected == 4'd1 && chk_ok) ? RX_DONE : RX_ERROR;
                    else if (expected == 4'd1)
                        state_next = RX_ERROR;
                end else begin
                    timer_next = timer + 1'b1;
                    if (timer == TW'(TIMEOUT - 1))
                        state_next = RX_ERROR;
                end
            end
            RX_DONE: begin
                commit     = 1'b1;
                state_next = RX_IDLE;
            end
            RX_ERROR: begin
                rollback   = 1'b1;
                state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    rx_commit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (tx_data),
        .commit   (commit),
        .rollback (rollback),
        .rd_en    (rd_en),
        .wr_full  (wr_full),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (fill_count)
    );

endmodule

// File: tb/tb_scan_transfer_receiver.sv
// Directed self-checking bench for scan_transfer_receiver (default parameters).
module tb_scan_transfer_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] scan_comm;
    logic [3:0] scan_count;
    logic       start_transfer;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic [7:0] tx_chk;
    logic       tx_ready;
    logic       rd_en;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] fill_count;
    logic [2:0] state_code;
    logic       xfer_error;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] chk_run;
    logic [7:0] norm_words [3] = '{8'hAA, 8'hBB, 8'hCC};

    scan_transfer_receiver #(
        .DATA_W  (8),
        .DEPTH   (16),
        .TIMEOUT (255)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .scan_comm      (scan_comm),
        .scan_count     (scan_count),
        .start_transfer (start_transfer),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_last        (tx_last),
        .tx_chk         (tx_chk),
        .tx_ready       (tx_ready),
        .rd_en          (rd_en),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .fill_count     (fill_count),
        .state_code     (state_code),
        .xfer_error     (xfer_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last, input logic bad);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = last;
        tx_chk   = chk_run ^ d ^ (bad ? 8'hFF : 8'h00);
        chk_run  = chk_run ^ d;
        tick();
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    // Request a transfer and advance through GRANT into RECEIVE
    task automatic open_transfer(input logic [3:0] n);
        scan_comm  = 2'b01;
        scan_count = n;
        chk_run    = 8'h00;
        tick();
        scan_comm = 2'b00;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if ({start_transfer, tx_ready, rd_valid, rd_data, fill_count, state_code, xfer_error} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: st=%b rdy=%b rv=%b rd=%h fc=%0d sc=%b err=%b, required all 0",
                     start_transfer, tx_ready, rd_valid, rd_data, fill_count, state_code, xfer_error);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        scan_comm  = 2'b01;
        scan_count = 4'd3;
        chk_run    = 8'h00;
        tick();
        tests++;
        if (start_transfer !== 1'b1 || state_code !== 3'b001) begin
            fails++;
            $display("FAIL normal_grant: st=%b sc=%b, required st=1 sc=001", start_transfer, state_code);
        end
        scan_comm = 2'b00;
        tick();
        tests++;
        if (start_transfer !== 1'b0 || state_code !== 3'b010 || tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL normal_receive: st=%b sc=%b rdy=%b, required st=0 sc=010 rdy=1",
                     start_transfer, state_code, tx_ready);
        end
        send_word(8'hAA, 1'b0, 1'b0);
        send_word(8'hBB, 1'b0, 1'b0);
        send_word(8'hCC, 1'b1, 1'b0);
        tests++;
        if (state_code !== 3'b011 || fill_count !== 5'd0) begin
            fails++;
            $display("FAIL normal_done: sc=%b fc=%0d, required sc=011 fc=0", state_code, fill_count);
        end
        tick();
        tests++;
        if (state_code !== 3'b000 || fill_count !== 5'd3 || xfer_error !== 1'b0) begin
            fails++;
            $display("FAIL normal_commit: sc=%b fc=%0d err=%b, required sc=000 fc=3 err=0",
                     state_code, fill_count, xfer_error);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== norm_words[i]) begin
                fails++;
                $display("FAIL normal_read%0d: rv=%b rd=%h, required rv=1 rd=%h", i, rd_valid, rd_data, norm_words[i]);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        tests++;
        if (fill_count !== 5'd0 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL normal_drained: fc=%0d rv=%b, required fc=0 rv=0", fill_count, rd_valid);
        end
    endtask

    task automatic test_flush();
        open_transfer(4'd5);
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        scan_comm = 2'b11;
        tx_valid  = 1'b1;
        tx_data   = 8'h33;
        tick();
        tx_valid  = 1'b0;
        scan_comm = 2'b00;
        tests++;
        if (state_code !== 3'b000 || fill_count !== 5'd0 || xfer_error !== 1'b0) begin
            fails++;
            $display("FAIL flush_abort: sc=%b fc=%0d err=%b, required sc=000 fc=0 err=0",
                     state_code, fill_count, xfer_error);
        end
        open_transfer(4'd1);
        send_word(8'h5A, 1'b1, 1'b0);
        tick();
        tests++;
        if (fill_count !== 5'd1 || rd_data !== 8'h5A) begin
            fails++;
            $display("FAIL flush_next: fc=%0d rd=%h, required fc=1 rd=5a", fill_count, rd_data);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_short();
        open_transfer(4'd4);
        send_word(8'h01, 1'b0, 1'b0);
        send_word(8'h02, 1'b1, 1'b0);
        tests++;
        if (state_code !== 3'b100) begin
            fails++;
            $display("FAIL short_error_state: sc=%b, required 100", state_code);
        end
        tick();
        tick();
        tick();
        tests++;
        if (xfer_error !== 1'b1 || fill_count !== 5'd0 || state_code !== 3'b000) begin
            fails++;
            $display("FAIL short_sticky: err=%b fc=%0d sc=%b, required err=1 fc=0 sc=000",
                     xfer_error, fill_count, state_code);
        end
    endtask

    task automatic test_overlength();
        open_transfer(4'd1);
        send_word(8'h77, 1'b0, 1'b0);
        tests++;
        if (state_code !== 3'b100) begin
            fails++;
            $display("FAIL overlength_state: sc=%b, required 100", state_code);
        end
        tick();
        tests++;
        if (fill_count !== 5'd0 || xfer_error !== 1'b1) begin
            fails++;
            $display("FAIL overlength_rollback: fc=%0d err=%b, required fc=0 err=1", fill_count, xfer_error);
        end
    endtask

    task automatic test_space_gate();
        open_transfer(4'd14);
        for (int i = 0; i < 14; i++)
            send_word(8'h10 + 8'(i), (i == 13), 1'b0);
        tick();
        tests++;
        if (fill_count !== 5'd14) begin
            fails++;
            $display("FAIL gate_preload: fc=%0d, required 14", fill_count);
        end
        scan_comm  = 2'b01;
        scan_count = 4'd3;
        chk_run    = 8'h00;
        tick();
        tick();
        tests++;
        if (state_code !== 3'b000 || start_transfer !== 1'b0) begin
            fails++;
            $display("FAIL gate_blocked: sc=%b st=%b, required sc=000 st=0", state_code, start_transfer);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        tests++;
        if (state_code !== 3'b001 || start_transfer !== 1'b1) begin
            fails++;
            $display("FAIL gate_grant: sc=%b st=%b, required sc=001 st=1", state_code, start_transfer);
        end
        scan_comm = 2'b00;
        tick();
        send_word(8'hE0, 1'b0, 1'b0);
        send_word(8'hE1, 1'b0, 1'b0);
        send_word(8'hE2, 1'b1, 1'b0);
        tick();
        tests++;
        if (fill_count !== 5'd16 || rd_data !== 8'h11) begin
            fails++;
            $display("FAIL gate_full: fc=%0d rd=%h, required fc=16 rd=11", fill_count, rd_data);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 17; i++)
            tick();
        rd_en = 1'b0;
        tests++;
        if (fill_count !== 5'd0 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL gate_empty_pop: fc=%0d rv=%b, required fc=0 rv=0", fill_count, rd_valid);
        end
    endtask

    task automatic test_timeout();
        open_transfer(4'd2);
        for (int i = 0; i < 254; i++)
            tick();
        tests++;
        if (state_code !== 3'b010) begin
            fails++;
            $display("FAIL timeout_early: sc=%b after 254 idle, required 010", state_code);
        end
        tick();
        tests++;
        if (state_code !== 3'b100) begin
            fails++;
            $display("FAIL timeout_fire: sc=%b after 255 idle, required 100", state_code);
        end
        tick();
        tests++;
        if (xfer_error !== 1'b1 || fill_count !== 5'd0) begin
            fails++;
            $display("FAIL timeout_error: err=%b fc=%0d, required err=1 fc=0", xfer_error, fill_count);
        end
    endtask

    task automatic test_reset_mid_receive();
        open_transfer(4'd3);
        send_word(8'h42, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tests++;
        if ({start_transfer, tx_ready, rd_valid, rd_data, fill_count, state_code, xfer_error} !== '0) begin
            fails++;
            $display("FAIL reset_mid: st=%b rdy=%b rv=%b rd=%h fc=%0d sc=%b err=%b, required all 0",
                     start_transfer, tx_ready, rd_valid, rd_data, fill_count, state_code, xfer_error);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_checksum();
        open_transfer(4'd2);
        send_word(8'h01, 1'b0, 1'b0);
        send_word(8'h02, 1'b1, 1'b1);
`ifdef RX_CHECKSUM_EN
        tests++;
        if (state_code !== 3'b100) begin
            fails++;
            $display("FAIL chk_bad: sc=%b, required 100", state_code);
        end
`else
        tests++;
        if (state_code !== 3'b011) begin
            fails++;
            $display("FAIL chk_ignored: sc=%b, required 011", state_code);
        end
`endif
        tick();
        open_transfer(4'd2);
        send_word(8'h0F, 1'b0, 1'b0);
        send_word(8'hF1, 1'b1, 1'b0);
        tests++;
        if (state_code !== 3'b011) begin
            fails++;
            $display("FAIL chk_good: sc=%b, required 011", state_code);
        end
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        scan_comm  = 2'b00;
        scan_count = 4'd0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        tx_last    = 1'b0;
        tx_chk     = 8'h00;
        rd_en      = 1'b0;
        chk_run    = 8'h00;
        test_reset();
        test_normal();
        test_flush();
        test_short();
        test_overlength();
        test_reset();
        test_space_gate();
        test_timeout();
        test_reset_mid_receive();
        test_checksum();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
